// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave word RAM with programmable wait states, byte-masked writes and a preload port.
// Optional feature: define STALL_LFSR_EN to add 0..3 pseudo-random extra wait cycles per access.
module avalon_wait_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned LOAD_AW     = $clog2(DEPTH_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [31:0]        writedata_i,
    input  logic [3:0]         byteenable_i,
    output logic               waitrequest_o,
    output logic [31:0]        readdata_o,
    input  logic               load_en_i,
    input  logic [LOAD_AW-1:0] load_addr_i,
    input  logic [31:0]        load_data_i,
    output logic               range_error_o
);

    localparam int unsigned CntW = 5;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rerr_q, rerr_d;
    logic [31:0]         mem [DEPTH_WORDS];

    logic [31:0]         offset;
    logic [29:0]         idx;
    logic [LOAD_AW-1:0]  word_idx;
    logic                in_range;
    logic [31:0]         mem_rd;
    logic                req;
    logic                is_rd;
    logic                mem_we;
    logic [CntW-1:0]     cnt_init;
    logic                unused_addr_bits;

    assign offset           = address_i - BASE_ADDR;
    assign idx              = offset[31:2];
    assign unused_addr_bits = ^offset[1:0];
    assign word_idx         = idx[LOAD_AW-1:0];
    assign in_range         = ({2'b00, idx} < 32'(DEPTH_WORDS));
    assign mem_rd           = in_range ? mem[word_idx] : 32'h0;
    assign req              = read_i | write_i;
    // A simultaneous read and write is handled as a write.
    assign is_rd            = read_i & ~write_i;

`ifdef STALL_LFSR_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign cnt_init = CntW'(WAIT_CYCLES) + CntW'(lfsr_q[1:0]);
`else
    assign cnt_init = CntW'(WAIT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && !load_en_i) begin
                    if (cnt_init == '0) begin
                        state_d = StResp;
                        if (is_rd) rdata_d = mem_rd;
                    end else begin
                        // The idle cycle already counts as the first high cycle.
                        state_d = StWait;
                        cnt_d   = cnt_init - CntW'(1);
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (!load_en_i) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        state_d = StResp;
                        if (is_rd) rdata_d = mem_rd;
                    end
                end
            end
            StResp: begin
                if (load_en_i) begin
                    // Re-enter the wait path so readdata reflects the freshly loaded word.
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                    if (req) begin
                        if (!in_range) rerr_d = 1'b1;
                        if (write_i && in_range) mem_we = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem[load_addr_i] <= load_data_i;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable_i[b]) mem[word_idx][8*b +: 8] <= writedata_i[8*b +: 8];
            end
        end
    end

    assign waitrequest_o = (req && (state_q != StResp)) || load_en_i;
    assign readdata_o    = rdata_q;
    assign range_error_o = rerr_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Scoreboard bench for avalon_wait_ram: driver pushes expected responses, monitor pops on completion.
// Honours STALL_LFSR_EN when the design is built with it.
module tb_avalon_wait_ram;

    localparam int unsigned Depth = 256;
    localparam logic [31:0] Base  = 32'hBFC00000;
    localparam int unsigned Wait  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address, writedata, rdata;
    logic        read, write, wait_req, rerr;
    logic [3:0]  be;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] address0, rdata0;
    logic        read0, wait_req0, rerr0;

    always #5 clk = ~clk;

    avalon_wait_ram #(
        .DEPTH_WORDS(Depth), .BASE_ADDR(Base), .WAIT_CYCLES(Wait), .LOAD_AW(8)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .address_i(address), .read_i(read), .write_i(write),
        .writedata_i(writedata), .byteenable_i(be), .waitrequest_o(wait_req),
        .readdata_o(rdata), .load_en_i(load_en), .load_addr_i(load_addr),
        .load_data_i(load_data), .range_error_o(rerr)
    );

    avalon_wait_ram #(
        .DEPTH_WORDS(Depth), .BASE_ADDR(Base), .WAIT_CYCLES(0), .LOAD_AW(8)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .address_i(address0), .read_i(read0), .write_i(1'b0),
        .writedata_i(32'h0), .byteenable_i(4'h0), .waitrequest_o(wait_req0),
        .readdata_o(rdata0), .load_en_i(load_en), .load_addr_i(load_addr),
        .load_data_i(load_data), .range_error_o(rerr0)
    );

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        rerr;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [Depth];
    logic [31:0] last_rdata;
    logic        exp_rerr;
    int          checks   = 0;
    int          failures = 0;

`ifdef STALL_LFSR_EN
    logic [7:0] lfsr_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 8'hA5;
        else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
    function automatic int lfsr_extra();
        return int'(lfsr_m[1:0]);
    endfunction
`else
    function automatic int lfsr_extra();
        return 0;
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete bus transaction; inject=1 fires a preload of idx3 during the response cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] bmask,
                          input bit inject, input string name);
        exp_t        e;
        logic [31:0] idx;
        bit          inr, done, loaded;
        int          extra;
        extra = lfsr_extra();
        idx   = (addr - Base) >> 2;
        inr   = (idx < Depth);
        if (inject) model[3] = 32'hDEADBEEF;
        if (wr) begin
            if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (bmask[b]) model[idx[7:0]][8*b +: 8] = wdata[8*b +: 8];
            end
        end else if (rd) begin
            last_rdata = inr ? model[idx[7:0]] : 32'h0;
        end
        if (!inr) exp_rerr = 1'b1;
        e.rdata = last_rdata;
        e.lat   = 1 + Wait + extra + (inject ? 2 : 0);
        e.rerr  = exp_rerr;
        e.name  = name;
        sb.push_back(e);
        address = addr; read = rd; write = wr; writedata = wdata; be = bmask;
        done = 0; loaded = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk); #1;
            if (!wait_req) begin
                if (inject && !loaded) begin
                    load_en = 1'b1; load_addr = 8'd3; load_data = 32'hDEADBEEF; loaded = 1;
                end else begin
                    done = 1;
                    break;
                end
            end
            @(posedge clk); #1;
            load_en = 1'b0;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no completion expected one within 64 cycles", name);
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    // Monitor: samples just before each rising edge, pops on every completed handshake.
    initial begin
        int    hi;
        bit    pend;
        logic  perr;
        string pname;
        exp_t  e;
        hi = 0; pend = 0; perr = 0;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) begin
                hi = 0; pend = 0;
            end else begin
                if (pend) begin
                    check({pname, "_range_error"}, {31'b0, rerr}, {31'b0, perr});
                    pend = 0;
                end
                if (read || write) begin
                    if (wait_req) begin
                        hi++;
                    end else if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_completion: got handshake expected none");
                        hi = 0;
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_readdata"}, rdata, e.rdata);
                        check({e.name, "_wait_cycles"}, 32'(hi), 32'(e.lat));
                        pend = 1; perr = e.rerr; pname = e.name;
                        hi = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] v, p1, p2, a, wd;
        int          op, sel;
        read = 0; write = 0; address = Base; writedata = 0; be = 0;
        load_en = 0; load_addr = 0; load_data = 0;
        read0 = 0; address0 = Base;
        last_rdata = 0; exp_rerr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        read = 1'b1;
        #1;
        check("reset_waitreq_follows_read", {31'b0, wait_req}, 32'd1);
        check("reset_readdata", rdata, 32'h0);
        check("reset_range_error", {31'b0, rerr}, 32'd0);
        check("reset_readdata_dut0", rdata0, 32'h0);
        read = 1'b0;
        #1;
        check("reset_waitreq_idle", {31'b0, wait_req}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < int'(Depth); i++) begin
            v = (i == 0) ? 32'h240300FF : (i == 4) ? 32'h0 : $urandom;
            load_en = 1'b1; load_addr = 8'(i); load_data = v; model[i] = v;
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        p1 = model[1]; p2 = model[2];

`ifndef STALL_LFSR_EN
        // Zero-wait instance: back-to-back reads show high, low, idle-high, low.
        address0 = Base + 32'd4; read0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #4;
            check("t4_waitrequest", {31'b0, wait_req0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 1) check("t4_readdata_idx1", rdata0, p1);
            if (k == 3) check("t4_readdata_idx2", rdata0, p2);
            @(posedge clk); #1;
            if (k == 1) address0 = Base + 32'd8;
        end
        read0 = 1'b0;
`endif

        access(1, 0, Base, 32'h0, 4'h0, 0, "t1_read_idx0");
        check("t1_value", rdata, 32'h240300FF);
        access(0, 1, Base + 32'h10, 32'h11223344, 4'b0101, 0, "t2_write");
        access(1, 0, Base + 32'h10, 32'h0, 4'h0, 0, "t2_readback");
        check("t2_value", rdata, 32'h00220044);
        check("t2_range_clear", {31'b0, rerr}, 32'd0);
        access(1, 0, Base + 32'h400, 32'h0, 4'h0, 0, "t3_oor_read");
        check("t3_oor_value", rdata, 32'h0);
        check("t3_range_set", {31'b0, rerr}, 32'd1);
        access(1, 0, Base + 32'hC, 32'h0, 4'h0, 0, "t3_inrange_after");
        check("t3_range_sticky", {31'b0, rerr}, 32'd1);

        for (int n = 0; n < 60; n++) begin
            op  = $urandom_range(0, 2);
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = Base + 4 * Depth + 32'($urandom_range(0, 255)) * 4;
            else if (sel == 1) a = Base - 32'($urandom_range(1, 16)) * 4;
            else               a = Base + (32'($urandom_range(0, Depth - 1)) << 2)
                                        + 32'($urandom_range(0, 3));
            wd = $urandom;
            access(op != 1, op != 0, a, wd, 4'($urandom_range(0, 15)), 0, "rand");
        end

        access(1, 0, Base + 32'hC, 32'h0, 4'h0, 1, "t5_load_in_resp");
        check("t5_value", rdata, 32'hDEADBEEF);

        // Reset in the middle of a write's wait phase must abort it cleanly.
        address = Base + 32'h14; writedata = 32'hCAFEF00D; be = 4'hF; write = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_readdata_reset", rdata, 32'h0);
        check("t6_range_reset", {31'b0, rerr}, 32'd0);
        check("t6_waitreq_in_reset", {31'b0, wait_req}, 32'd1);
        write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rdata = 0; exp_rerr = 0;
        access(1, 0, Base + 32'h14, 32'h0, 4'h0, 0, "t6_target_unmodified");

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
